// File: rtl/regfile_if.sv
// regfile_if -- debug access port of the register file.
//   dbg_req_i    : request valid (held stable until dbg_ready_o)
//   dbg_we_i     : 1 = write, 0 = read
//   dbg_addr_i   : register address
//   dbg_wdata_i  : write data
//   dbg_ready_o  : request accepted this cycle
//   dbg_rdata_o  : registered read data
//   dbg_rvalid_o : one-cycle pulse qualifying dbg_rdata_o
// master = requester, slave = register file.
interface regfile_if #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32
);
  logic             dbg_req_i;
  logic             dbg_we_i;
  logic [AddrW-1:0] dbg_addr_i;
  logic [DataW-1:0] dbg_wdata_i;
  logic             dbg_ready_o;
  logic [DataW-1:0] dbg_rdata_o;
  logic             dbg_rvalid_o;

  modport master (
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_ready_o, dbg_rdata_o, dbg_rvalid_o
  );

  modport slave (
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_ready_o, dbg_rdata_o, dbg_rvalid_o
  );
endinterface

// File: rtl/regfile.sv
// regfile -- integer register file, x0 hardwired to zero.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   reg_waddr_i/wdata_i/wen_i: writeback write port (priority over debug)
//   raddr1_i/raddr2_i        : combinational read addresses
//   rdata1_o/rdata2_o        : combinational read data
//   dbg                      : debug access port (regfile_if.slave)
// Optional build macro REGFILE_BYPASS_EN: forward writeback data to the
// read ports in the cycle of the write.
module regfile #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] reg_waddr_i,
  input  logic [DataW-1:0] reg_wdata_i,
  input  logic             reg_wen_i,
  input  logic [AddrW-1:0] raddr1_i,
  input  logic [AddrW-1:0] raddr2_i,
  output logic [DataW-1:0] rdata1_o,
  output logic [DataW-1:0] rdata2_o,
  regfile_if.slave         dbg
);

  localparam int unsigned NumRegs = 2 ** AddrW;

  // x0 has no storage; words 1..NumRegs-1 only.
  logic [DataW-1:0] mem_q [1:NumRegs-1];
  logic [DataW-1:0] dbg_rdata_q;
  logic             dbg_rvalid_q;
  logic             dbg_ready;
  logic             dbg_wr;
  logic             dbg_rd;

  function automatic logic [DataW-1:0] read_word(input logic [AddrW-1:0] a);
    if (a == '0) return '0;
    return mem_q[a];
  endfunction

  // Writeback owns the cycle; debug is only accepted when writeback is idle.
  assign dbg_ready = dbg.dbg_req_i & ~reg_wen_i;
  assign dbg_wr    = dbg_ready &  dbg.dbg_we_i;
  assign dbg_rd    = dbg_ready & ~dbg.dbg_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 1; i < NumRegs; i++) mem_q[i] <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      // Loop starts at 1, so writes to x0 fall through untouched.
      for (int unsigned i = 1; i < NumRegs; i++) begin
        if (reg_wen_i && reg_waddr_i == AddrW'(i)) begin
          mem_q[i] <= reg_wdata_i;
        end else if (dbg_wr && dbg.dbg_addr_i == AddrW'(i)) begin
          mem_q[i] <= dbg.dbg_wdata_i;
        end
      end
      dbg_rvalid_q <= dbg_rd;
      if (dbg_rd) dbg_rdata_q <= read_word(dbg.dbg_addr_i);
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata1_o = read_word(raddr1_i);
    rdata2_o = read_word(raddr2_i);
    if (reg_wen_i && reg_waddr_i != '0 && raddr1_i == reg_waddr_i) rdata1_o = reg_wdata_i;
    if (reg_wen_i && reg_waddr_i != '0 && raddr2_i == reg_waddr_i) rdata2_o = reg_wdata_i;
  end
`else
  always_comb begin
    rdata1_o = read_word(raddr1_i);
    rdata2_o = read_word(raddr2_i);
  end
`endif

  assign dbg.dbg_ready_o  = dbg_ready;
  assign dbg.dbg_rdata_o  = dbg_rdata_q;
  assign dbg.dbg_rvalid_o = dbg_rvalid_q;

endmodule
